// File: rtl/demux_pkg.sv
// Shared types and default sizing for the flow-controlled 1-to-N demux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_OUT = 4;
    localparam int SEL_W     = $clog2(DEF_N_OUT);

    // EMPTY: no word held. FULL: word and its destination are latched.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/dmux_onehot.sv
// Binary select plus enable decoded to a one-hot vector.
// Latency: purely combinational.
// Backpressure: none; output is all-zero when disabled.
module dmux_onehot #(
    parameter int SEL_W = 2,
    parameter int N_OUT = 4
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_en,
    output logic [N_OUT-1:0] o_onehot
);

    // Set exactly the selected bit when enabled, nothing otherwise.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_dispatcher.sv
// One-entry buffered 1-to-N dispatcher: routed or round-robin destination.
// Latency: word loaded at edge k is offered on out_valid from cycle k+1.
// Backpressure: holds FULL while out_ready[dest]=0; in_ready passes out_ready[dest] through.
module demux_dispatcher
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OUT = DEF_N_OUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_rr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(N_OUT)-1:0] in_sel,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [15:0]              xfer_count
);

    localparam int SW = $clog2(N_OUT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [SW-1:0]     r_dest;
    logic [SW-1:0]     r_rr_ptr;
    logic [15:0]       r_xfer_count;

    logic              w_full;
    logic [N_OUT-1:0]  w_dest_oh;
    logic              w_xfer;
    logic              w_load;

    assign w_full = (r_state == FULL);

    // Offer the held word only to its latched destination.
    dmux_onehot #(.SEL_W(SW), .N_OUT(N_OUT)) u_valid_dec (
        .i_sel    (r_dest),
        .i_en     (w_full),
        .o_onehot (out_valid)
    );

    // Same decode, used to pick the one out_ready bit that matters.
    dmux_onehot #(.SEL_W(SW), .N_OUT(N_OUT)) u_ready_dec (
        .i_sel    (r_dest),
        .i_en     (1'b1),
        .o_onehot (w_dest_oh)
    );

    assign w_xfer     = w_full && |(w_dest_oh & out_ready);
    // Accept when empty, or when the held word leaves this same cycle.
    assign in_ready   = !w_full || w_xfer;
    assign w_load     = in_valid && in_ready;
    assign out_data   = r_data;
    assign xfer_count = r_xfer_count;

    // Next-state: a load always ends FULL; a transfer alone drains to EMPTY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_load) w_state_nxt = FULL;
            FULL:    if (w_xfer && !w_load) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // State, buffer, destination, round-robin pointer and transfer counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= EMPTY;
            r_data       <= '0;
            r_dest       <= '0;
            r_rr_ptr     <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= in_data;
                r_dest <= cfg_rr ? r_rr_ptr : in_sel;
                // N_OUT is a power of two, so natural wrap is mod N_OUT.
                if (cfg_rr) begin
                    r_rr_ptr <= r_rr_ptr + SW'(1);
                end
            end
            if (w_xfer) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
module tb_demux_dispatcher;

    logic        clk;
    logic        reset;
    logic        cfg_rr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic [15:0] xfer_count;

    demux_dispatcher #(.WIDTH(16), .N_OUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_rr     (cfg_rr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] m_rr     = 2'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (!reset && |(out_valid & out_ready)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected actual=%b/%0h required=no transfer", out_valid, out_data);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.port;
                    if (out_valid !== oh || out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_xfer actual=%b/%0h required=%b/%0h", out_valid, out_data, oh, e.data);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the loading edge.
    task automatic drive_word(input logic rr, input logic [1:0] sel, input logic [15:0] d,
                              output int stalls);
        bit   done;
        exp_t e;
        stalls   = 0;
        done     = 0;
        cfg_rr   = rr;
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL load_timeout actual=in_ready 0 required=in_ready 1");
                    done = 1;
                end
            end
        end
        if (stalls <= 50) begin
            e.port = rr ? m_rr : sel;
            e.data = d;
            if (rr) m_rr = m_rr + 2'd1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int st;
        int tot;
        reset     = 1'b1;
        cfg_rr    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_xfer_count", 32'(xfer_count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Routed load to port 2.
        @(posedge clk); #1;
        out_ready = 4'hF;
        drive_word(1'b0, 2'd2, 16'hBEEF, st);
        @(negedge clk);
        chk("routed_valid", 32'(out_valid), 32'h4);
        chk("routed_data", 32'(out_data), 32'hBEEF);
        @(negedge clk);
        chk("routed_empty", 32'(out_valid), 32'h0);
        chk("routed_count", 32'(xfer_count), 32'h1);

        // Round-robin streaming, six back-to-back words.
        @(posedge clk); #1;
        tot = 0;
        for (int i = 1; i <= 6; i++) begin
            drive_word(1'b1, 2'd3, 16'(i), st);
            tot += st;
        end
        chk("rr_no_stall", 32'(tot), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rr_count", 32'(xfer_count), 32'd7);

        // Backpressure on port 1 while port 0 is ready.
        @(posedge clk); #1;
        out_ready = 4'b0001;
        drive_word(1'b0, 2'd1, 16'h1234, st);
        cfg_rr  = 1'b1;
        in_sel  = 2'd3;
        in_data = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'h2);
            chk("bp_data", 32'(out_data), 32'h1234);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_count", 32'(xfer_count), 32'd7);
        end
        @(posedge clk); #1;
        cfg_rr    = 1'b0;
        out_ready = 4'b0010;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        chk("bp_release_empty", 32'(out_valid), 32'h0);
        chk("bp_release_count", 32'(xfer_count), 32'd8);

        // Simultaneous transfer and load.
        @(posedge clk); #1;
        out_ready = 4'hF;
        drive_word(1'b0, 2'd3, 16'h0055, st);
        drive_word(1'b0, 2'd0, 16'h00AA, st);
        chk("sim_no_stall", 32'(st), 32'h0);
        @(negedge clk);
        chk("sim_valid", 32'(out_valid), 32'h1);
        chk("sim_data", 32'(out_data), 32'h00AA);
        @(negedge clk);
        chk("sim_count", 32'(xfer_count), 32'd10);

        // Reset while stalled on port 2.
        @(posedge clk); #1;
        out_ready = 4'h0;
        drive_word(1'b0, 2'd2, 16'h7777, st);
        @(negedge clk);
        chk("mid_full_valid", 32'(out_valid), 32'h4);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_rr = 2'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_count", 32'(xfer_count), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        out_ready = 4'hF;
        drive_word(1'b1, 2'd3, 16'h0C0C, st);
        @(negedge clk);
        chk("mid_rr_port0", 32'(out_valid), 32'h1);
        @(negedge clk);
        chk("mid_count", 32'(xfer_count), 32'h1);

        // Counter wrap: 65534 more transfers to reach 0xFFFF, then one more.
        @(posedge clk); #1;
        tot = 0;
        for (int i = 0; i < 65534; i++) begin
            drive_word(1'b0, 2'(i), 16'(i), st);
            tot += st;
        end
        chk("wrap_no_stall", 32'(tot), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_ffff", 32'(xfer_count), 32'hFFFF);
        @(posedge clk); #1;
        drive_word(1'b0, 2'd1, 16'hCAFE, st);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_zero", 32'(xfer_count), 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
